// File: rtl/shifter_pkg.sv
// Shared types and constants for the iterative shifter: shift kinds, FSM states,
// datapath width and the iteration-count helper.
package shifter_pkg;

  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Rotates only need n mod 16 steps; shifts saturate at a full-width shift.
  function automatic logic [CNT_W-1:0] iter_count(input shift_type_e t, input logic [7:0] n);
    if (t == ROR)
      return {1'b0, n[3:0]};
    else if (n > 8'd16)
      return CNT_W'(16);
    else
      return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next accumulator value and the bit shifted out.
module shift_step
  import shifter_pkg::*;
(
  input  logic [SHIFT_W-1:0] i_acc,
  input  shift_type_e        i_type,
  output logic [SHIFT_W-1:0] o_next,
  output logic               o_bit
);

  always_comb begin
    o_next = i_acc;
    o_bit  = 1'b0;
    unique case (i_type)
      LSL: begin
        o_next = {i_acc[SHIFT_W-2:0], 1'b0};
        o_bit  = i_acc[SHIFT_W-1];
      end
      LSR: begin
        o_next = {1'b0, i_acc[SHIFT_W-1:1]};
        o_bit  = i_acc[0];
      end
      ASR: begin
        o_next = {i_acc[SHIFT_W-1], i_acc[SHIFT_W-1:1]};
        o_bit  = i_acc[0];
      end
      ROR: begin
        o_next = {i_acc[0], i_acc[SHIFT_W-1:1]};
        o_bit  = i_acc[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative 16-bit barrel-shift replacement: one bit per cycle, valid/ready handshake.
// Optional ITER_SHIFTER_EARLY_EXIT_EN ends a shift once the accumulator reaches its fill value.
module iter_shifter
  import shifter_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [SHIFT_W-1:0] rd_data_i,
  input  logic [SHIFT_W-1:0] rm_data_i,
  input  logic [1:0]         shift_type_i,
  input  logic               carry_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [SHIFT_W-1:0] data_shifted_o,
  output logic               negative_o,
  output logic               zero_o,
  output logic               carry_o
);

  state_e             r_state;
  logic               r_ready;
  logic               r_valid;
  logic [SHIFT_W-1:0] r_data;
  logic               r_neg;
  logic               r_zero;
  logic               r_cout;
  logic [SHIFT_W-1:0] r_acc;
  shift_type_e        r_type;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_over;

  logic [7:0]         w_n;
  shift_type_e        w_type_in;
  logic [CNT_W-1:0]   w_cnt_init;
  logic               w_zero_carry;
  logic               w_over;
  logic               w_unused_rm;
  logic [SHIFT_W-1:0] w_next;
  logic               w_bit;
  logic               w_last;
  logic               w_early;
  logic               w_early_c;
  logic               w_fin_c;

  assign w_n         = rm_data_i[7:0];
  assign w_unused_rm = ^rm_data_i[SHIFT_W-1:8];
  assign w_type_in   = shift_type_e'(shift_type_i);
  assign w_cnt_init  = iter_count(w_type_in, w_n);
  // A rotate by a nonzero multiple of 16 leaves the data alone but still defines C.
  assign w_zero_carry = (w_type_in == ROR && w_n != '0) ? rd_data_i[SHIFT_W-1] : carry_i;
  assign w_over       = (w_type_in == LSL || w_type_in == LSR) && (w_n > 8'd16);

  shift_step u_step (
    .i_acc  (r_acc),
    .i_type (r_type),
    .o_next (w_next),
    .o_bit  (w_bit)
  );

`ifdef ITER_SHIFTER_EARLY_EXIT_EN
  logic [SHIFT_W-1:0] w_fill;
  assign w_fill    = (r_type == ASR) ? {SHIFT_W{r_acc[SHIFT_W-1]}} : '0;
  assign w_early   = (r_type != ROR) && (w_next == w_fill);
  assign w_early_c = w_fill[0];
`else
  assign w_early   = 1'b0;
  assign w_early_c = 1'b0;
`endif

  assign w_last  = (r_cnt == CNT_W'(1));
  assign w_fin_c = w_last ? (r_over ? 1'b0 : w_bit) : w_early_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_cout  <= 1'b0;
      r_acc   <= '0;
      r_type  <= LSL;
      r_cnt   <= '0;
      r_over  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_acc   <= rd_data_i;
            r_type  <= w_type_in;
            r_cnt   <= w_cnt_init;
            r_over  <= w_over;
            r_ready <= 1'b0;
            if (w_cnt_init == '0) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
              r_data  <= rd_data_i;
              r_neg   <= rd_data_i[SHIFT_W-1];
              r_zero  <= (rd_data_i == '0);
              r_cout  <= w_zero_carry;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last || w_early) begin
            r_state <= S_DONE;
            r_valid <= 1'b1;
            r_data  <= w_next;
            r_neg   <= w_next[SHIFT_W-1];
            r_zero  <= (w_next == '0);
            r_cout  <= w_fin_c;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o        = r_ready;
  assign valid_o        = r_valid;
  assign data_shifted_o = r_data;
  assign negative_o     = r_neg;
  assign zero_o         = r_zero;
  assign carry_o        = r_cout;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: directed vectors push expected results,
// a negedge monitor pops and compares each time valid_o rises.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] rd_data_i;
  logic [15:0] rm_data_i;
  logic [1:0]  shift_type_i;
  logic        carry_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_shifted_o;
  logic        negative_o;
  logic        zero_o;
  logic        carry_o;

  always #5 clk = ~clk;

  iter_shifter dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .rd_data_i      (rd_data_i),
    .rm_data_i      (rm_data_i),
    .shift_type_i   (shift_type_i),
    .carry_i        (carry_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .data_shifted_o (data_shifted_o),
    .negative_o     (negative_o),
    .zero_o         (zero_o),
    .carry_o        (carry_o)
  );

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        n;
    logic        z;
    logic        c;
    int          lat;
    time         t_acc;
  } exp_t;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] rd;
    logic [7:0]  n;
    logic        cin;
    logic [15:0] ed;
    logic        ec;
    int          lat;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   seen    = 1'b0;
  exp_t m_e;
  int   m_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per rising valid_o.
  always @(negedge clk) begin
    if (!valid_o) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid_o=1 data=0x%h, expected no result", data_shifted_o);
      end else begin
        m_e   = q.pop_front();
        m_lat = int'(($time - m_e.t_acc - 64'd5) / 64'd10) + 1;
        check($sformatf("v%0d_latency", m_e.id), m_lat, m_e.lat);
        check($sformatf("v%0d_data", m_e.id), {16'h0, data_shifted_o}, {16'h0, m_e.data});
        check($sformatf("v%0d_nzc", m_e.id), {29'h0, negative_o, zero_o, carry_o},
              {29'h0, m_e.n, m_e.z, m_e.c});
      end
    end
  end

  task automatic send(input int id, input logic [1:0] t, input logic [15:0] rd, input logic [7:0] n,
                      input logic cin, input logic [15:0] ed, input logic ec, input int lat,
                      input bit push);
    exp_t e;
    int   k = 0;
    @(negedge clk);
    while (!ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      check($sformatf("v%0d_ready_timeout", id), 32'd0, 32'd1);
      return;
    end
    shift_type_i = t;
    rd_data_i    = rd;
    rm_data_i    = {8'hA5, n};
    carry_i      = cin;
    valid_i      = 1'b1;
    @(posedge clk);
    if (push) begin
      e.id    = id;
      e.data  = ed;
      e.n     = ed[15];
      e.z     = (ed == 16'h0);
      e.c     = ec;
      e.lat   = lat;
      e.t_acc = $time;
      q.push_back(e);
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int k = 0;
    while (q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      check($sformatf("v%0d_result_timeout", id), 32'd0, 32'd1);
      void'(q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int viol;
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    rd_data_i = '0; rm_data_i = '0; shift_type_i = 2'b00; carry_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, ready_o}, 32'd1);
    check("rst_valid", {31'h0, valid_o}, 32'd0);
    check("rst_data", {16'h0, data_shifted_o}, 32'd0);
    check("rst_nzc", {29'h0, negative_o, zero_o, carry_o}, 32'd0);
    reset_i = 1'b0;

    //                t      rd        n      cin   result    C     latency
    vecs.push_back('{2'b00, 16'h0001, 8'd16, 1'b0, 16'h0000, 1'b1, 17});
`ifdef ITER_SHIFTER_EARLY_EXIT_EN
    vecs.push_back('{2'b10, 16'h8000, 8'd20, 1'b0, 16'hFFFF, 1'b1, 16});
    vecs.push_back('{2'b01, 16'h0100, 8'd12, 1'b0, 16'h0000, 1'b0, 10});
`else
    vecs.push_back('{2'b10, 16'h8000, 8'd20, 1'b0, 16'hFFFF, 1'b1, 17});
    vecs.push_back('{2'b01, 16'h0100, 8'd12, 1'b0, 16'h0000, 1'b0, 13});
`endif
    vecs.push_back('{2'b11, 16'h00F1, 8'h14, 1'b0, 16'h100F, 1'b0, 5});
    vecs.push_back('{2'b01, 16'h1234, 8'd0,  1'b1, 16'h1234, 1'b1, 1});
    vecs.push_back('{2'b00, 16'h8001, 8'd1,  1'b0, 16'h0002, 1'b1, 2});
    vecs.push_back('{2'b01, 16'h0003, 8'd2,  1'b0, 16'h0000, 1'b1, 3});
    vecs.push_back('{2'b01, 16'hFFFF, 8'd17, 1'b1, 16'h0000, 1'b0, 17});
    vecs.push_back('{2'b11, 16'hABCD, 8'd16, 1'b0, 16'hABCD, 1'b1, 1});
    vecs.push_back('{2'b10, 16'h4000, 8'd3,  1'b1, 16'h0800, 1'b0, 4});
    vecs.push_back('{2'b11, 16'h0001, 8'd1,  1'b0, 16'h8000, 1'b1, 2});
    vecs.push_back('{2'b00, 16'h00FF, 8'd8,  1'b1, 16'hFF00, 1'b0, 9});
    vecs.push_back('{2'b10, 16'h8000, 8'd0,  1'b0, 16'h8000, 1'b0, 1});

    foreach (vecs[i]) begin
      send(i, vecs[i].t, vecs[i].rd, vecs[i].n, vecs[i].cin, vecs[i].ed, vecs[i].ec, vecs[i].lat, 1'b1);
      wait_done(i);
    end

    // Backpressure: result held for 5 cycles while a competing request is offered.
    ready_i = 1'b0;
    send(100, 2'b11, 16'h1234, 8'd4, 1'b1, 16'h4123, 1'b0, 5, 1'b1);
    k = 0;
    while (!valid_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid_seen", {31'h0, valid_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      shift_type_i = 2'b00; rd_data_i = 16'hFFFF; rm_data_i = 16'h0001; valid_i = 1'b1;
      check($sformatf("bp%0d_valid", i), {31'h0, valid_o}, 32'd1);
      check($sformatf("bp%0d_ready", i), {31'h0, ready_o}, 32'd0);
      check($sformatf("bp%0d_data", i), {16'h0, data_shifted_o}, 32'h4123);
      check($sformatf("bp%0d_nzc", i), {29'h0, negative_o, zero_o, carry_o}, 32'd0);
      @(negedge clk);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'h0, ready_o}, 32'd1);
    check("bp_release_valid", {31'h0, valid_o}, 32'd0);
    wait_done(100);

    // Reset in BUSY, with a coincident request that must lose to reset.
    send(200, 2'b00, 16'h0001, 8'd10, 1'b0, 16'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    reset_i = 1'b1;
    shift_type_i = 2'b01; rd_data_i = 16'h5555; rm_data_i = 16'h0000; valid_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    valid_i = 1'b0;
    check("abort_ready", {31'h0, ready_o}, 32'd1);
    check("abort_valid", {31'h0, valid_o}, 32'd0);
    check("abort_data", {16'h0, data_shifted_o}, 32'd0);
    check("abort_nzc", {29'h0, negative_o, zero_o, carry_o}, 32'd0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o) viol++;
    end
    check("abort_no_valid", viol, 32'd0);

    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
